if_stage: RTL and testbench

Instruction-fetch stage sitting between the `pc` register and the decode stage. Consumes the current PC, issues in-order instruction-memory requests over a valid/ready handshake, and drives `next_pc`/`en` back into `pc`. Buffers returned instructions, each paired with its PC, in a small in-order queue that drains to decode. Handles control-flow redirects by flushing the queue and discarding responses to requests still in flight.

---
 rtl/if_stage_if.sv | 32 +++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: pc register,
// execute redirect, instruction memory and decode.
interface if_stage_if;
  logic [31:0] pc_in;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    input  pc_in, redirect_valid, redirect_target, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, if_ready,
    output pc_en, next_pc, imem_req_valid, imem_req_addr,
           if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_in, redirect_valid, redirect_target, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, if_ready,
    input  pc_en, next_pc, imem_req_valid, imem_req_addr,
           if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order memory requests, queues returned
// instructions with their PCs, and flushes on redirect while draining stale responses.
module if_stage #(
  parameter int DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] alloc_q, alloc_d, unfilled_q, unfilled_d, drop_q, drop_d;

  logic [CW:0]   inflight;
  logic [CW-1:0] owed;
  logic [31:0]   req_addr;
  logic          req_valid, accept, rsp_drop, rsp_fill, deq;
  logic [DEPTH-1:0] alloc_hit, fill_hit, free_hit;

  assign req_addr  = {bus.pc_in[31:2], 2'b00};
  assign inflight  = {1'b0, alloc_q} + {1'b0, drop_q};
  assign req_valid = !rst && !bus.redirect_valid && (inflight < LIMIT);
  assign accept    = req_valid && bus.imem_req_ready;
  assign rsp_drop  = !rst && bus.imem_rsp_valid && (drop_q != '0);
  // Unfilled entries are contiguous from fill_q, since responses return in order.
  assign rsp_fill  = !rst && !bus.redirect_valid && bus.imem_rsp_valid &&
                     (drop_q == '0) && (unfilled_q != '0);
  assign deq       = bus.if_valid && bus.if_ready;
  assign owed      = drop_q + unfilled_q;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.if_valid       = !rst && !bus.redirect_valid && filled_q[head_q];
  assign bus.if_instr       = instr_q[head_q];
  assign bus.if_pc          = pc_q[head_q];

  always_comb begin
    bus.pc_en   = 1'b0;
    bus.next_pc = bus.pc_in;
    if (!rst && bus.redirect_valid) begin
      bus.pc_en   = 1'b1;
      bus.next_pc = {bus.redirect_target[31:2], 2'b00};
    end else if (accept) begin
      bus.pc_en   = 1'b1;
      bus.next_pc = req_addr + 32'd4;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    unfilled_d = unfilled_q;
    drop_d     = drop_q;
    if (bus.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      alloc_d    = '0;
      unfilled_d = '0;
      // Every unfilled entry still owes a response; one arriving now is consumed.
      drop_d     = (bus.imem_rsp_valid && owed != '0) ? owed - 1'b1 : owed;
    end else begin
      if (accept)   tail_d = tail_q + 1'b1;
      if (rsp_fill) fill_d = fill_q + 1'b1;
      if (deq)      head_d = head_q + 1'b1;
      if (rsp_drop) drop_d = drop_q - 1'b1;
      alloc_d    = alloc_q + CW'(accept) - CW'(deq);
      unfilled_d = unfilled_q + CW'(accept) - CW'(rsp_fill);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign alloc_hit[gi] = accept   && (tail_q == PW'(gi));
    assign fill_hit[gi]  = rsp_fill && (fill_q == PW'(gi));
    assign free_hit[gi]  = deq      && (head_q == PW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      unfilled_q <= unfilled_d;
      drop_q     <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.redirect_valid || free_hit[i] || alloc_hit[i]) filled_q[i] <= 1'b0;
        else if (fill_hit[i])                                  filled_q[i] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: filled_q gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_hit[i]) pc_q[i]    <= req_addr;
      if (fill_hit[i])  instr_q[i] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, streaming, PC wrap,
// then randomized traffic against a queue-based reference model.
module tb_if_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] addr; int cyc; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
  typedef struct {
    logic r, rdv; logic [31:0] rdt; logic rrdy, rsp, ird;
    logic e_rv; logic [31:0] e_addr; logic e_pcen; logic [31:0] e_npc;
    logic e_iv; logic [31:0] e_ipc;
  } vec_t;

  pend_t pend_q[$];   // requests accepted by memory, response not yet returned
  item_t ready_q[$];  // fetched instructions waiting for decode
  int stale_n;        // leading pend_q entries whose responses must be thrown away
  logic [31:0] pc_reg;
  int cyc, checks, failures;

  logic a_rv, a_pcen, a_iv, dlv;
  logic [31:0] a_addr, a_npc, a_ipc, dlv_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdv, input logic [31:0] rdt,
                      input logic rrdy, input logic want_rsp, input logic ird);
    logic rsp, e_rv, e_acc, e_pcen, e_iv;
    logic [31:0] e_addr, e_npc;
    pend_t p;
    item_t it;
    rsp = 1'b0;
    if (want_rsp && !r && pend_q.size() > 0) rsp = (pend_q[0].cyc < cyc);
    rst = r;
    bus.redirect_valid  = rdv;
    bus.redirect_target = rdt;
    bus.imem_req_ready  = rrdy;
    bus.imem_rsp_valid  = rsp;
    bus.imem_rsp_data   = $urandom;
    if (rsp) bus.imem_rsp_data = memf(pend_q[0].addr);
    bus.if_ready = ird;
    bus.pc_in    = pc_reg;

    e_addr = {pc_reg[31:2], 2'b00};
    e_rv   = !r && !rdv && (pend_q.size() + ready_q.size() < DEPTH);
    e_acc  = e_rv && rrdy;
    e_pcen = !r && (rdv || e_acc);
    e_npc  = rdv ? {rdt[31:2], 2'b00} : (e_acc ? e_addr + 32'd4 : pc_reg);
    e_iv   = !r && !rdv && (ready_q.size() > 0);

    @(negedge clk);
    a_rv = bus.imem_req_valid; a_addr = bus.imem_req_addr;
    a_pcen = bus.pc_en; a_npc = bus.next_pc;
    a_iv = bus.if_valid; a_ipc = bus.if_pc;
    check("req_valid", a_rv, e_rv);
    if (e_rv) check("req_addr", a_addr, e_addr);
    check("pc_en", a_pcen, e_pcen);
    if (!r) check("next_pc", a_npc, e_npc);
    check("if_valid", a_iv, e_iv);
    if (e_iv) begin
      check("if_pc", a_ipc, ready_q[0].pc);
      check("if_instr", bus.if_instr, ready_q[0].instr);
    end
    dlv = e_iv && ird;
    dlv_pc = a_ipc;

    if (r) begin
      pend_q.delete(); ready_q.delete(); stale_n = 0;
    end else begin
      if (e_iv && ird) void'(ready_q.pop_front());
      if (rsp) begin
        p = pend_q.pop_front();
        if (stale_n > 0) stale_n--;
        else if (!rdv) begin
          it.pc = p.addr; it.instr = memf(p.addr);
          ready_q.push_back(it);
        end
      end
      if (e_acc) begin
        p.addr = e_addr; p.cyc = cyc;
        pend_q.push_back(p);
      end
      if (rdv) begin
        ready_q.delete();
        stale_n = pend_q.size();
      end
      if (e_pcen) pc_reg = e_npc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic vec_t mk(logic r, logic rdv, logic [31:0] rdt, logic rrdy, logic rsp,
                              logic ird, logic e_rv, logic [31:0] e_addr, logic e_pcen,
                              logic [31:0] e_npc, logic e_iv, logic [31:0] e_ipc);
    vec_t v;
    v.r = r; v.rdv = rdv; v.rdt = rdt; v.rrdy = rrdy; v.rsp = rsp; v.ird = ird;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_pcen = e_pcen; v.e_npc = e_npc;
    v.e_iv = e_iv; v.e_ipc = e_ipc;
    return v;
  endfunction

  vec_t tab [26];
  int n_stream, n_rand;
  logic [31:0] stream_pc, rdt;

  initial begin
    //            r rdv rdt        rrdy rsp ird  rv addr     pcen npc        iv ipc
    tab[0]  = mk(1, 1, 32'h40,     1, 0, 1,   0, 0,        0, 0,          0, 0);
    tab[1]  = mk(1, 1, 32'h40,     1, 0, 1,   0, 0,        0, 0,          0, 0);
    tab[2]  = mk(0, 0, 0,          0, 0, 0,   1, 32'h0,    0, 0,          0, 0);
    tab[3]  = mk(0, 0, 0,          1, 0, 0,   1, 32'h0,    1, 32'h4,      0, 0);
    tab[4]  = mk(0, 0, 0,          1, 0, 0,   1, 32'h4,    1, 32'h8,      0, 0);
    tab[5]  = mk(0, 0, 0,          1, 1, 0,   0, 0,        0, 0,          0, 0);
    tab[6]  = mk(0, 0, 0,          1, 1, 0,   0, 0,        0, 0,          1, 32'h0);
    tab[7]  = mk(0, 0, 0,          1, 0, 0,   0, 0,        0, 0,          1, 32'h0);
    tab[8]  = mk(0, 0, 0,          1, 0, 1,   0, 0,        0, 0,          1, 32'h0);
    tab[9]  = mk(0, 0, 0,          1, 0, 1,   1, 32'h8,    1, 32'hC,      1, 32'h4);
    tab[10] = mk(0, 0, 0,          1, 0, 1,   1, 32'hC,    1, 32'h10,     0, 0);
    tab[11] = mk(0, 1, 32'h2003,   1, 0, 1,   0, 0,        1, 32'h2000,   0, 0);
    tab[12] = mk(0, 0, 0,          1, 1, 1,   0, 0,        0, 0,          0, 0);
    tab[13] = mk(0, 0, 0,          1, 1, 1,   1, 32'h2000, 1, 32'h2004,   0, 0);
    tab[14] = mk(0, 0, 0,          1, 0, 1,   1, 32'h2004, 1, 32'h2008,   0, 0);
    tab[15] = mk(0, 0, 0,          1, 1, 1,   0, 0,        0, 0,          0, 0);
    tab[16] = mk(0, 0, 0,          0, 0, 1,   0, 0,        0, 0,          1, 32'h2000);
    tab[17] = mk(0, 0, 0,          1, 0, 1,   1, 32'h2008, 1, 32'h200C,   0, 0);
    tab[18] = mk(0, 0, 0,          0, 1, 0,   0, 0,        0, 0,          0, 0);
    tab[19] = mk(0, 0, 0,          0, 0, 1,   0, 0,        0, 0,          1, 32'h2004);
    tab[20] = mk(0, 1, 32'h300,    1, 1, 1,   0, 0,        1, 32'h300,    0, 0);
    tab[21] = mk(0, 0, 0,          1, 0, 1,   1, 32'h300,  1, 32'h304,    0, 0);
    tab[22] = mk(0, 0, 0,          1, 0, 1,   1, 32'h304,  1, 32'h308,    0, 0);
    tab[23] = mk(0, 0, 0,          1, 1, 1,   0, 0,        0, 0,          0, 0);
    tab[24] = mk(0, 0, 0,          1, 1, 1,   0, 0,        0, 0,          1, 32'h300);
    tab[25] = mk(0, 0, 0,          0, 0, 1,   1, 32'h308,  0, 0,          1, 32'h304);

    checks = 0; failures = 0; cyc = 0; stale_n = 0; pc_reg = 32'h0;
    rst = 1'b1;
    bus.pc_in = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.if_ready = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      step(tab[i].r, tab[i].rdv, tab[i].rdt, tab[i].rrdy, tab[i].rsp, tab[i].ird);
      check($sformatf("tab%0d_req_valid", i), a_rv, tab[i].e_rv);
      if (tab[i].e_rv) check($sformatf("tab%0d_req_addr", i), a_addr, tab[i].e_addr);
      check($sformatf("tab%0d_pc_en", i), a_pcen, tab[i].e_pcen);
      if (tab[i].e_pcen) check($sformatf("tab%0d_next_pc", i), a_npc, tab[i].e_npc);
      check($sformatf("tab%0d_if_valid", i), a_iv, tab[i].e_iv);
      if (tab[i].e_iv) check($sformatf("tab%0d_if_pc", i), a_ipc, tab[i].e_ipc);
    end

    // Streaming from 0x100 with an always-ready memory and decode.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    pc_reg = 32'h100; stream_pc = 32'h100; n_stream = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 1, 1, 1);
      if (dlv) begin
        check("stream_pc", dlv_pc, stream_pc);
        stream_pc += 32'd4;
        n_stream++;
      end
    end
    check("stream_count_ok", 32'(n_stream >= 20), 32'd1);

    // PC wrap at the top of the address space.
    step(1, 0, 0, 0, 0, 0);
    pc_reg = 32'hFFFF_FFFC;
    step(0, 0, 0, 1, 0, 1);
    check("wrap_pc_en", a_pcen, 1'b1);
    check("wrap_next_pc", a_npc, 32'h0);

    n_rand = 0;
    for (int i = 0; i < 3000; i++) begin
      rdt = $urandom & 32'h0000_3FFF;
      if ($urandom_range(0, 7) == 0) rdt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, rdt,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
      if (dlv) n_rand++;
    end
    check("rand_progress_ok", 32'(n_rand > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
